// File: rtl/uart_echo_fifo.sv
// UART echo engine: buffers received bytes in a FIFO and replays them to the
// transmitter with an optional transform, plus occupancy/overflow/activity status.
module uart_echo_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LED_HOLD = 1_200_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_ready,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic [1:0]              mode,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              overflow_cnt,
    output logic                    led
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LED_W = $clog2(LED_HOLD + 1);

    localparam logic [AW:0]        FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [LED_W-1:0]   LED_LOAD = LED_W'(LED_HOLD);
    localparam logic [1:0]         MODE_UPPER = 2'd1;
    localparam logic [1:0]         MODE_MUTE  = 2'd2;
    localparam logic [1:0]         MODE_CRLF  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_LF   = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [1:0]        state;
    logic              pending_lf;
    logic [LED_W-1:0]  led_cnt;

    logic              push_req;
    logic              push;
    logic              drop;
    logic              pop;
    logic [DATA_W-1:0] head;

    function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] b,
                                                 input logic [1:0] m);
        if (m == MODE_UPPER && b >= DATA_W'(8'h61) && b <= DATA_W'(8'h7A))
            return b - DATA_W'(8'h20);
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
    assign push_req = rx_ready && (mode != MODE_MUTE);
    assign push     = push_req && (fifo_level != FULL_LVL);
    assign drop     = push_req && (fifo_level == FULL_LVL);
    assign pop      = (state == S_IDLE) && (fifo_level != '0) && !tx_busy;
    assign head     = mem[rd_ptr];
    assign led      = (led_cnt != '0);

    // Storage array carries data only and is never reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow_cnt <= '0;
            led_cnt      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
            if (drop)
                overflow_cnt <= sat_inc(overflow_cnt);
            if (push)
                led_cnt <= LED_LOAD;
            else if (led_cnt != '0)
                led_cnt <= led_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            pending_lf <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data    <= xform(head, mode);
                        tx_start   <= 1'b1;
                        pending_lf <= (mode == MODE_CRLF) && (head == DATA_W'(8'h0D));
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        state    <= pending_lf ? S_LF : S_IDLE;
                    end
                end
                S_LF: begin
                    if (!tx_busy) begin
                        tx_data    <= DATA_W'(8'h0A);
                        tx_start   <= 1'b1;
                        pending_lf <= 1'b0;
                        state      <= S_SEND;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
